// File: rtl/alu_op_sequencer.sv
// Hardwired T0-T5 control unit for the bus datapath: fetches through MAR/MDR/IR
// and executes three-register ALU instructions, with a memory-ready wait state.
module alu_op_sequencer #(
    parameter int OPW  = 5,
    parameter int NREG = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            PCin,
    output logic            read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zlowin,
    output logic            ZLOout,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [OPW-1:0]  operation,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T1W,
        T2,
        DEC,
        T3,
        T4,
        T5
    } state_e;

    localparam logic [NREG-1:0] ONE_HOT_LSB = {{(NREG-1){1'b0}}, 1'b1};

    state_e     state_q;
    state_e     state_d;
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       legal_op;
    logic       unused_ir_bits;

    assign opcode         = ir[31:27];
    assign ra             = ir[26:23];
    assign rb             = ir[22:19];
    assign rc             = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    // Supported ALU group: add, sub, and, or, shr, shra, shl, ror, rol.
    assign legal_op = (opcode >= 5'd3) && (opcode <= 5'd11);

    // NOTE: non-blocking assignment so the state flop samples pre-edge values only.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output and state_d takes a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        PCin      = 1'b0;
        read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zlowin    = 1'b0;
        ZLOout    = 1'b0;
        Rin       = '0;
        Rout      = '0;
        operation = '0;
        done      = 1'b0;
        illegal   = 1'b0;
        busy      = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = T0;
                end
            end
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                state_d = T1;
            end
            T1: begin
                ZLOout  = 1'b1;
                PCin    = 1'b1;
                read    = 1'b1;
                MDRin   = 1'b1;
                state_d = mem_ready ? T2 : T1W;
            end
            // PC was already written in T1; the wait state only keeps the read open.
            T1W: begin
                read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) begin
                    state_d = T2;
                end
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = DEC;
            end
            DEC: begin
                if (legal_op) begin
                    state_d = T3;
                end else begin
                    illegal = 1'b1;
                    state_d = IDLE;
                end
            end
            T3: begin
                Rout    = ONE_HOT_LSB << rb;
                Yin     = 1'b1;
                state_d = T4;
            end
            T4: begin
                Rout      = ONE_HOT_LSB << rc;
                Zlowin    = 1'b1;
                operation = OPW'(opcode);
                state_d   = T5;
            end
            T5: begin
                ZLOout  = 1'b1;
                Rin     = ONE_HOT_LSB << ra;
                done    = 1'b1;
                state_d = run ? T0 : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
